// File: rtl/countdown_pkg.sv
// Shared state type, button indices and 7-segment constants (active-low, bit 6 = g .. bit 0 = a)
// for the countdown timer.
package countdown_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   localparam int NUM_BTN        = 6;
   localparam int BTN_SUB_HOUR   = 0;
   localparam int BTN_ADD_HOUR   = 1;
   localparam int BTN_SUB_MINUTE = 2;
   localparam int BTN_ADD_MINUTE = 3;
   localparam int BTN_START_STOP = 4;
   localparam int BTN_CLEAR      = 5;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/button_press_sync.sv
// Active-low push-button synchroniser (resets to released) with a registered one-cycle
// press pulse on the falling edge; pin-to-pulse latency is STAGES+1 clocks.
module button_press_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_n,
   output logic o_press
);

   // Bit STAGES is one extra flop holding the previous synchroniser output for edge detection.
   logic [STAGES:0] r_sync;
   logic            r_press;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '1;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[STAGES-1:0], i_btn_n};
         r_press <= r_sync[STAGES] & ~r_sync[STAGES-1];
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with push-button preset, run/pause and expiry flag.
// Optional macro COUNTDOWN_BLINK_EN: blink the display at 1 Hz while expired.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int TICK_COUNT      = 50_000_000,
   parameter int DEBOUNCE_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       add_minute,
   input  logic       subtract_minute,
   input  logic       add_hour,
   input  logic       subtract_hour,
   output logic [6:0] second_1,
   output logic [6:0] second_2,
   output logic [6:0] minute_1,
   output logic [6:0] minute_2,
   output logic [6:0] hour_1,
   output logic [6:0] hour_2,
   output logic       running,
   output logic       expired
);

   localparam int            PW     = $clog2(TICK_COUNT);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_COUNT - 1);

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_hr_t;
   logic [3:0]    r_hr_u;
   logic [2:0]    r_min_t, r_sec_t;
   logic [3:0]    r_min_u, r_sec_u;
   logic [6:0]    r_seg [NUM_BTN];
   logic          r_running, r_expired;

   logic [NUM_BTN-1:0] w_btn_n, w_press;
   logic [1:0]         w_hr_t_next, w_dec_hr_t;
   logic [3:0]         w_hr_u_next, w_dec_hr_u, w_min_u_next, w_dec_min_u, w_dec_sec_u;
   logic [2:0]         w_min_t_next, w_dec_min_t, w_dec_sec_t;
   logic               w_time_zero, w_time_one, w_blank;
   logic [3:0]         w_digit [6];

   assign w_btn_n = {clear, start_stop, add_minute, subtract_minute, add_hour, subtract_hour};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         button_press_sync #(.STAGES(DEBOUNCE_STAGES)) u_btn (
            .clk     (clk),
            .rst     (rst),
            .i_btn_n (w_btn_n[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   assign w_time_zero = (r_hr_t == 2'd0) && (r_hr_u == 4'd0) && (r_min_t == 3'd0)
                     && (r_min_u == 4'd0) && (r_sec_t == 3'd0) && (r_sec_u == 4'd0);
   assign w_time_one  = (r_hr_t == 2'd0) && (r_hr_u == 4'd0) && (r_min_t == 3'd0)
                     && (r_min_u == 4'd0) && (r_sec_t == 3'd0) && (r_sec_u == 4'd1);

   // Hour/minute edit, highest-priority set button wins; minutes never carry into hours.
   always_comb begin
      w_min_t_next = r_min_t;
      w_min_u_next = r_min_u;
      w_hr_t_next  = r_hr_t;
      w_hr_u_next  = r_hr_u;
      if (w_press[BTN_ADD_MINUTE]) begin
         if (r_min_u != 4'd9) w_min_u_next = r_min_u + 4'd1;
         else begin
            w_min_u_next = 4'd0;
            w_min_t_next = (r_min_t == 3'd5) ? 3'd0 : r_min_t + 3'd1;
         end
      end else if (w_press[BTN_SUB_MINUTE]) begin
         if (r_min_u != 4'd0) w_min_u_next = r_min_u - 4'd1;
         else begin
            w_min_u_next = 4'd9;
            w_min_t_next = (r_min_t == 3'd0) ? 3'd5 : r_min_t - 3'd1;
         end
      end else if (w_press[BTN_ADD_HOUR]) begin
         if (r_hr_t == 2'd2 && r_hr_u == 4'd3) begin
            w_hr_t_next = 2'd0;
            w_hr_u_next = 4'd0;
         end else if (r_hr_u == 4'd9) begin
            w_hr_t_next = r_hr_t + 2'd1;
            w_hr_u_next = 4'd0;
         end else w_hr_u_next = r_hr_u + 4'd1;
      end else if (w_press[BTN_SUB_HOUR]) begin
         if (r_hr_t == 2'd0 && r_hr_u == 4'd0) begin
            w_hr_t_next = 2'd2;
            w_hr_u_next = 4'd3;
         end else if (r_hr_u == 4'd0) begin
            w_hr_t_next = r_hr_t - 2'd1;
            w_hr_u_next = 4'd9;
         end else w_hr_u_next = r_hr_u - 4'd1;
      end
   end

   // One-second decrement with BCD borrow; never applied to 00:00:00.
   always_comb begin
      w_dec_hr_t  = r_hr_t;
      w_dec_hr_u  = r_hr_u;
      w_dec_min_t = r_min_t;
      w_dec_min_u = r_min_u;
      w_dec_sec_t = r_sec_t;
      w_dec_sec_u = r_sec_u - 4'd1;
      if (r_sec_u == 4'd0) begin
         w_dec_sec_u = 4'd9;
         w_dec_sec_t = r_sec_t - 3'd1;
         if (r_sec_t == 3'd0) begin
            w_dec_sec_t = 3'd5;
            w_dec_min_u = r_min_u - 4'd1;
            if (r_min_u == 4'd0) begin
               w_dec_min_u = 4'd9;
               w_dec_min_t = r_min_t - 3'd1;
               if (r_min_t == 3'd0) begin
                  w_dec_min_t = 3'd5;
                  w_dec_hr_u  = r_hr_u - 4'd1;
                  if (r_hr_u == 4'd0) begin
                     w_dec_hr_u = 4'd9;
                     w_dec_hr_t = r_hr_t - 2'd1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_press[BTN_CLEAR]) begin
         r_state <= IDLE;
         r_presc <= '0;
         r_hr_t  <= '0;
         r_hr_u  <= '0;
         r_min_t <= '0;
         r_min_u <= '0;
         r_sec_t <= '0;
         r_sec_u <= '0;
      end else if (w_press[BTN_START_STOP]) begin
         case (r_state)
            IDLE: if (!w_time_zero) begin
               r_state <= RUN;
               r_presc <= '0;
            end
            RUN:     r_state <= PAUSE;
            PAUSE:   r_state <= w_time_zero ? IDLE : RUN;
            default: begin
               r_state <= IDLE;
               r_presc <= '0;
            end
         endcase
      end else begin
         case (r_state)
            RUN: if (r_presc == P_LAST) begin
               r_presc <= '0;
               r_hr_t  <= w_dec_hr_t;
               r_hr_u  <= w_dec_hr_u;
               r_min_t <= w_dec_min_t;
               r_min_u <= w_dec_min_u;
               r_sec_t <= w_dec_sec_t;
               r_sec_u <= w_dec_sec_u;
               if (w_time_one) r_state <= EXPIRED;
            end else r_presc <= r_presc + PW'(1);
            EXPIRED: begin
`ifdef COUNTDOWN_BLINK_EN
               r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
`else
               r_presc <= '0;
`endif
            end
            default: begin
               r_hr_t  <= w_hr_t_next;
               r_hr_u  <= w_hr_u_next;
               r_min_t <= w_min_t_next;
               r_min_u <= w_min_u_next;
            end
         endcase
      end
   end

`ifdef COUNTDOWN_BLINK_EN
   localparam logic [PW-1:0] P_HALF = PW'(TICK_COUNT / 2);
   assign w_blank = (r_state == EXPIRED) && (r_presc >= P_HALF);
`else
   assign w_blank = 1'b0;
`endif

   assign w_digit[0] = r_sec_u;
   assign w_digit[1] = {1'b0, r_sec_t};
   assign w_digit[2] = r_min_u;
   assign w_digit[3] = {1'b0, r_min_t};
   assign w_digit[4] = r_hr_u;
   assign w_digit[5] = {2'b00, r_hr_t};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_running <= 1'b0;
         r_expired <= 1'b0;
         for (int i = 0; i < 6; i++) r_seg[i] <= SEG_0;
      end else begin
         r_running <= (r_state == RUN);
         r_expired <= (r_state == EXPIRED);
         for (int i = 0; i < 6; i++) r_seg[i] <= w_blank ? SEG_BLANK : seg_decode(w_digit[i]);
      end
   end

   assign second_1 = r_seg[0];
   assign second_2 = r_seg[1];
   assign minute_1 = r_seg[2];
   assign minute_2 = r_seg[3];
   assign hour_1   = r_seg[4];
   assign hour_2   = r_seg[5];
   assign running  = r_running;
   assign expired  = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (TICK_COUNT=4); build with COUNTDOWN_BLINK_EN to
// exercise the expired-blink variant. Reference model keeps the time as plain seconds.
`timescale 1ns/1ps
module tb_countdown_timer;

   localparam int T  = 4;
   localparam int DS = 2;
`ifdef COUNTDOWN_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic       clk, rst;
   logic [5:0] btn_n;   // 5 clear, 4 start_stop, 3 add_min, 2 sub_min, 1 add_hr, 0 sub_hr
   logic [6:0] second_1, second_2, minute_1, minute_2, hour_1, hour_2;
   logic       running, expired;

   int n_checks = 0;
   int n_errors = 0;

   countdown_timer #(.TICK_COUNT(T), .DEBOUNCE_STAGES(DS)) dut (
      .clk             (clk),
      .rst             (rst),
      .start_stop      (btn_n[4]),
      .clear           (btn_n[5]),
      .add_minute      (btn_n[3]),
      .subtract_minute (btn_n[2]),
      .add_hour        (btn_n[1]),
      .subtract_hour   (btn_n[0]),
      .second_1        (second_1),
      .second_2        (second_2),
      .minute_1        (minute_1),
      .minute_2        (minute_2),
      .hour_1          (hour_1),
      .hour_2          (hour_2),
      .running         (running),
      .expired         (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7f;
      endcase
   endfunction

   function automatic logic [43:0] mk_vec(input int h, input int m, input int s,
                                          input bit run, input bit ex);
      return {seg7(h / 10), seg7(h % 10), seg7(m / 10), seg7(m % 10),
              seg7(s / 10), seg7(s % 10), run, ex};
   endfunction

   // ---------------- reference model: time in seconds, press latency DS+1 from the pin
   int          m_state, m_t, m_p, d_t;
   bit          d_run, d_exp, d_blank;
   logic [DS+2:0] hist [6];

   always @(posedge clk) begin : model
      int nt, np, ns, h, m, s;
      logic [DS+2:0] nh;
      logic [5:0]    pr;
      if (rst) begin
         m_state <= M_IDLE; m_t <= 0; m_p <= 0;
         d_t <= 0; d_run <= 1'b0; d_exp <= 1'b0; d_blank <= 1'b0;
         for (int b = 0; b < 6; b++) hist[b] <= '1;
      end else begin
         pr = '0;
         for (int b = 0; b < 6; b++) begin
            nh = {hist[b][DS+1:0], btn_n[b]};
            hist[b] <= nh;
            pr[b] = !nh[DS+1] && nh[DS+2];
         end
         nt = m_t; np = m_p; ns = m_state;
         h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
         if (pr[5]) begin
            nt = 0; np = 0; ns = M_IDLE;
         end else if (pr[4]) begin
            case (m_state)
               M_IDLE:  if (m_t != 0) begin ns = M_RUN; np = 0; end
               M_RUN:   ns = M_PAUSE;
               M_PAUSE: ns = (m_t != 0) ? M_RUN : M_IDLE;
               default: begin ns = M_IDLE; np = 0; end
            endcase
         end else if (m_state == M_RUN) begin
            if (m_p == T - 1) begin
               np = 0; nt = m_t - 1;
               if (nt == 0) ns = M_EXP;
            end else np = m_p + 1;
         end else if (m_state == M_EXP) begin
            np = BLINK ? (m_p + 1) % T : 0;
         end else begin
            if (pr[3])      m = (m + 1) % 60;
            else if (pr[2]) m = (m + 59) % 60;
            else if (pr[1]) h = (h + 1) % 24;
            else if (pr[0]) h = (h + 23) % 24;
            nt = h * 3600 + m * 60 + s;
         end
         d_t     <= m_t;
         d_run   <= (m_state == M_RUN);
         d_exp   <= (m_state == M_EXP);
         d_blank <= BLINK && (m_state == M_EXP) && (m_p >= T / 2);
         m_t <= nt; m_p <= np; m_state <= ns;
      end
   end

   logic [43:0] exp_vec, dut_vec;
   always_comb begin
      exp_vec = mk_vec(d_t / 3600, (d_t / 60) % 60, d_t % 60, d_run, d_exp);
      if (d_blank) exp_vec[43:2] = {6{7'h7f}};
   end
   assign dut_vec = {hour_2, hour_1, minute_2, minute_1, second_2, second_1, running, expired};

   // ---------------- stimulus helpers (no checking)
   task automatic hold(input int b, input int n);
      btn_n[b] = 1'b0;
      repeat (n) @(negedge clk);
      btn_n[b] = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      rst = 1'b1; btn_n = '1;
      wait_cyc(3);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== mk_vec(0, 0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset_idle cyc %0d got %h want %h", i, dut_vec, mk_vec(0, 0, 0, 0, 0));
         end
      end
      hold(4, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL ss_at_zero cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      n_checks++;
      if (running !== 1'b0) begin
         n_errors++;
         $display("FAIL ss_at_zero_running got %b want 0", running);
      end
   endtask

   task automatic test_set_and_run();
      hold(3, 1); wait_cyc(4);
      hold(3, 1); wait_cyc(4);
      hold(0, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL set_edit cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      n_checks++;
      if (dut_vec !== mk_vec(23, 2, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL set_display got %h want %h", dut_vec, mk_vec(23, 2, 0, 0, 0));
      end
      hold(4, 1);
      for (int i = 0; i < 20 && running !== 1'b1; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL start cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      n_checks++;
      if (dut_vec !== mk_vec(23, 2, 0, 1, 0)) begin
         n_errors++;
         $display("FAIL start_running got %h want %h", dut_vec, mk_vec(23, 2, 0, 1, 0));
      end
      wait_cyc(4);
      n_checks++;
      if (dut_vec !== mk_vec(23, 1, 59, 1, 0)) begin
         n_errors++;
         $display("FAIL first_tick got %h want %h", dut_vec, mk_vec(23, 1, 59, 1, 0));
      end
   endtask

   task automatic test_expire();
      hold(5, 1); wait_cyc(6);
      hold(3, 1); wait_cyc(6);
      hold(4, 1);
      for (int i = 0; i < 20 && running !== 1'b1; i++) @(negedge clk);
      wait_cyc(4);
      n_checks++;
      if (dut_vec !== mk_vec(0, 0, 59, 1, 0)) begin
         n_errors++;
         $display("FAIL expire_first_tick got %h want %h", dut_vec, mk_vec(0, 0, 59, 1, 0));
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL countdown cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
         if (expired === 1'b1) break;
      end
      n_checks++;
      if (dut_vec !== mk_vec(0, 0, 0, 0, 1)) begin
         n_errors++;
         $display("FAIL expire_edge got %h want %h", dut_vec, mk_vec(0, 0, 0, 0, 1));
      end
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL expired_hold cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_pause_resume();
      hold(5, 1); wait_cyc(6);
      hold(3, 1); wait_cyc(6);
      hold(4, 1);
      // Press so that it takes effect with the prescaler at 2 and the time at 00:00:10.
      for (int i = 0; i < 400 && !(m_t == 11 && m_p == 3 && m_state == M_RUN); i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL run_to_10 cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      hold(4, 1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL pausing cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      n_checks++;
      if (dut_vec !== mk_vec(0, 0, 10, 0, 0)) begin
         n_errors++;
         $display("FAIL paused got %h want %h", dut_vec, mk_vec(0, 0, 10, 0, 0));
      end
      hold(1, 1); wait_cyc(6);
      n_checks++;
      if (dut_vec !== mk_vec(1, 0, 10, 0, 0)) begin
         n_errors++;
         $display("FAIL pause_add_hour got %h want %h", dut_vec, mk_vec(1, 0, 10, 0, 0));
      end
      hold(4, 1);
      for (int i = 0; i < 20 && running !== 1'b1; i++) @(negedge clk);
      n_checks++;
      if (dut_vec !== mk_vec(1, 0, 10, 1, 0)) begin
         n_errors++;
         $display("FAIL resume_edge got %h want %h", dut_vec, mk_vec(1, 0, 10, 1, 0));
      end
      @(negedge clk);
      n_checks++;
      if (dut_vec !== mk_vec(1, 0, 10, 1, 0)) begin
         n_errors++;
         $display("FAIL resume_plus1 got %h want %h", dut_vec, mk_vec(1, 0, 10, 1, 0));
      end
      @(negedge clk);
      n_checks++;
      if (dut_vec !== mk_vec(1, 0, 9, 1, 0)) begin
         n_errors++;
         $display("FAIL resume_tick got %h want %h", dut_vec, mk_vec(1, 0, 9, 1, 0));
      end
   endtask

   task automatic test_clear_priority();
      btn_n[5] = 1'b0; btn_n[4] = 1'b0; btn_n[3] = 1'b0;
      @(negedge clk);
      btn_n = '1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL clearing cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      n_checks++;
      if (dut_vec !== mk_vec(0, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL clear_priority got %h want %h", dut_vec, mk_vec(0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_reset_mid_run();
      hold(3, 1); wait_cyc(4);
      hold(4, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL pre_reset cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_vec !== mk_vec(0, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL reset_mid_run got %h want %h", dut_vec, mk_vec(0, 0, 0, 0, 0));
      end
      rst = 1'b0;
      wait_cyc(2);
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL random cyc %0d got %h want %h", i, dut_vec, exp_vec);
         end
         btn_n = '1;
         r = $urandom_range(0, 99);
         if (r < 2)       btn_n[5] = 1'b0;
         else if (r < 8)  btn_n[4] = 1'b0;
         else if (r < 14) btn_n[3] = 1'b0;
         else if (r < 18) btn_n[2] = 1'b0;
         else if (r < 22) btn_n[1] = 1'b0;
         else if (r < 25) btn_n[0] = 1'b0;
      end
      btn_n = '1;
   endtask

   initial begin
      rst = 1'b1;
      btn_n = '1;
      test_reset();
      test_set_and_run();
      test_expire();
      test_pause_resume();
      test_clear_priority();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog timeout checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
